pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It merges stall requests from ID (load-use hazard) and EX (multi-cycle ALU operations), and flush requests from the exception path. It drives a per-stage stall vector to the PC register and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It owns the multi-cycle sequencing for EX so the ALU can hold an operation in the ID/EX register until it completes.

## Interface
- MC_CYCLES, default 32: total EX occupancy in cycles of a multi-cycle operation (must be ≥ 2).
- CNT_W, default 6: width of the multi-cycle down-counter (must hold MC_CYCLES-1).
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stallreq_id  input  1  ID-stage hazard; hold PC, IF/ID and ID/EX this cycle.
- ex_mc_start  input  1  EX began a multi-cycle op (sampled only in IDLE).
- flush_req  input  1  exception/redirect; flush all stages.
- stall  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- flush  output  1  clear all pipeline registers to NOP this cycle.
- mc_busy  output  1  multi-cycle op in progress.
- mc_done  output  1  one-cycle pulse; EX result valid this cycle.
- mc_abort  output  1  one-cycle pulse; multi-cycle op killed by flush.

## Operation
- Three states: IDLE, MC, FLUSH. Reset state is IDLE with the counter at 0.
- IDLE:
  - flush_req → FLUSH.
  - Otherwise ex_mc_start → MC, counter loaded with MC_CYCLES-2.
  - Otherwise stay.
- MC:
  - flush_req → FLUSH with mc_abort=1.
  - Otherwise, if counter == 0, mc_done=1 and → IDLE.
  - Otherwise counter decrements.
- FLUSH: lasts one cycle, then → IDLE. Requests arriving in FLUSH are ignored; the stall/flush outputs still follow the priority rules below.
- Stall vector is combinational from state and inputs. Priority: flush > EX > ID.
  - flush_req, or state FLUSH: stall=6'b000000, flush=1.
  - ex_mc_start in IDLE, or state MC with counter ≠ 0: stall=6'b001111.
  - MC with counter == 0: stall=6'b000000. The ID/EX register releases as the result commits.
  - stallreq_id (no higher request): stall=6'b000111.
  - Else stall=6'b000000.
- mc_busy=1 whenever state is MC, and in the IDLE cycle where ex_mc_start is accepted.
- ex_mc_start asserted while in MC is ignored; EX must not re-pulse it.
- stallreq_id during MC is masked by the EX stall, which is a superset of it.

## Timing
- Every output is 0 while rst is low, and immediately on assertion (async). First active edge after release sees IDLE.
- Multi-cycle op: stall[3:0] is high for MC_CYCLES-1 consecutive cycles, counted from the ex_mc_start cycle. mc_done is high in cycle MC_CYCLES-1 after start, i.e. occupancy is MC_CYCLES cycles.
- flush is high in the request cycle and in the following FLUSH cycle: two cycles total for a single-cycle flush_req.
- mc_done and mc_abort are mutually exclusive. When flush_req and counter == 0 coincide, abort wins.
- There is no registered output delay; the controller adds zero pipeline latency.

## Configuration
- STALL_PERF_EN defined: adds output perf_stall_cnt[31:0].
  - Increments on every cycle where stall[0]=1.
  - Saturates at 32'hFFFFFFFF.
  - Clears on reset.
- STALL_PERF_EN undefined: no counter and no port; behaviour is otherwise identical.

## Test plan
- Reset mid-MC: start an op, pull rst low at cycle 5 → all outputs 0 at once. After release the block is IDLE and stall=0 with no stray mc_done.
- Load-use: stallreq_id=1 for 1 cycle in IDLE → stall=6'b000111 that cycle only, flush=0.
- Multi-cycle (MC_CYCLES=32): ex_mc_start pulse → stall=6'b001111 for 31 cycles, then mc_done=1 and stall=0 in cycle 31, mc_busy falls next cycle.
- Flush during MC at cycle 10 → flush=1 for 2 cycles, mc_abort=1 at cycle 10, stall=0, no mc_done afterwards.
- Collision: flush_req and the counter==0 cycle together → mc_abort=1, mc_done=0. stallreq_id plus ex_mc_start together → stall=6'b001111.
- STALL_PERF_EN: 3 ID stalls plus one 32-cycle op → perf_stall_cnt=34. Preload near max → value holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges ID/EX stalls and exception flushes and sequences EX multi-cycle ops.
// Latency: zero; stall/flush/pulses are combinational from state and inputs. Backpressure: drives per-stage hold vector.
// Optional STALL_PERF_EN adds a saturating count of cycles in which the PC is held (perf_stall_cnt).
module pipe_ctrl #(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       ex_mc_start,
    input  logic       flush_req,
    output logic [5:0] stall,
    output logic       flush,
    output logic       mc_busy,
    output logic       mc_done,
    output logic       mc_abort
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MC    = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;
    logic [5:0]       stall_c;
    logic             flush_c, busy_c, done_c, abort_c;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 6'b000000;
        flush_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        abort_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (ex_mc_start) begin
                    state_d = S_MC;
                    cnt_d   = MC_LOAD;
                end
            end
            S_MC: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_c = (state_q == S_MC) || ((state_q == S_IDLE) && ex_mc_start && !flush_req);

        // Priority: flush, then EX multi-cycle hold/release, then ID hazard.
        if (flush_req || (state_q == S_FLUSH)) begin
            flush_c = 1'b1;
            abort_c = (state_q == S_MC);
        end else if (((state_q == S_IDLE) && ex_mc_start) || ((state_q == S_MC) && !cnt_zero)) begin
            stall_c = 6'b001111;
        end else if (state_q == S_MC) begin
            done_c = 1'b1;
        end else if (stallreq_id) begin
            stall_c = 6'b000111;
        end
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign stall    = rst ? stall_c : 6'b000000;
    assign flush    = rst & flush_c;
    assign mc_busy  = rst & busy_c;
    assign mc_done  = rst & done_c;
    assign mc_abort = rst & abort_c;

`ifdef STALL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (stall[0] && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes hand-derived expected output words, a negedge monitor pops and compares.
// Output word layout: {stall[5:0], flush, mc_busy, mc_done, mc_abort}.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stallreq_id, ex_mc_start, flush_req;
    logic [5:0] stall;
    logic       flush, mc_busy, mc_done, mc_abort;
    logic [9:0] act;
`ifdef STALL_PERF_EN
    logic [31:0] perf;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] v;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [9:0] E_IDLE  = 10'b000000_0000;
    localparam logic [9:0] E_ID    = 10'b000111_0000;
    localparam logic [9:0] E_MC    = 10'b001111_0100;
    localparam logic [9:0] E_DONE  = 10'b000000_0110;
    localparam logic [9:0] E_ABORT = 10'b000000_1101;
    localparam logic [9:0] E_FL    = 10'b000000_1000;

    pipe_ctrl #(.MC_CYCLES(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .ex_mc_start (ex_mc_start),
        .flush_req   (flush_req),
        .stall       (stall),
        .flush       (flush),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done),
        .mc_abort    (mc_abort)
`ifdef STALL_PERF_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    assign act = {stall, flush, mc_busy, mc_done, mc_abort};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b (stall,flush,busy,done,abort)", e.nm, act, e.v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue that cycle's expected outputs.
    task automatic step(input logic r, input logic sid, input logic mcs, input logic fr,
                        input logic [9:0] e, input string nm);
        rst         = r;
        stallreq_id = sid;
        ex_mc_start = mcs;
        flush_req   = fr;
        exp_q.push_back('{v: e, nm: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic mc_body(input int first, input int last, input string nm);
        for (int i = first; i <= last; i++) step(1'b1, 1'b0, 1'b0, 1'b0, E_MC, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; stallreq_id = 1'b0; ex_mc_start = 1'b0; flush_req = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_outputs", {22'd0, act}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, E_IDLE, "reset_masks_inputs");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "reset_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "post_reset_idle");

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, E_ID, "load_use");
            step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "load_use_release");
        end

        // Full 32-cycle op; ID stall and a stray start inside MC must not change anything.
        step(1'b1, 1'b0, 1'b1, 1'b0, E_MC, "mc_start");
        for (int i = 1; i <= 30; i++)
            step(1'b1, (i == 5), (i == 7), 1'b0, E_MC, "mc_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_DONE, "mc_done_cycle31");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "mc_busy_fall");
`ifdef STALL_PERF_EN
        chk("perf_34", perf, 32'd34);
`endif

        step(1'b1, 1'b0, 1'b1, 1'b0, E_MC, "abort_start");
        mc_body(1, 9, "abort_hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, E_ABORT, "flush_abort_cycle10");
        step(1'b1, 1'b0, 1'b1, 1'b0, E_FL, "flush_second_cycle");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "no_done_after_abort");

        step(1'b1, 1'b0, 1'b1, 1'b0, E_MC, "coll_start");
        mc_body(1, 30, "coll_hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, E_ABORT, "abort_beats_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_FL, "coll_flush_2nd");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "coll_idle");

        step(1'b1, 1'b1, 1'b1, 1'b0, E_MC, "id_plus_mc_start");
        mc_body(1, 30, "id_plus_mc_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_DONE, "id_plus_mc_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "id_plus_mc_idle");

        step(1'b1, 1'b0, 1'b0, 1'b1, E_FL, "flush_idle");
        step(1'b1, 1'b1, 1'b0, 1'b0, E_FL, "flush_state_masks_id");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "flush_idle_done");
        step(1'b1, 1'b1, 1'b1, 1'b1, E_FL, "flush_over_start");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_FL, "flush_over_start_2nd");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "no_mc_after_flush");

        // Reset pulled mid-op at cycle 5 with requests still active.
        step(1'b1, 1'b0, 1'b1, 1'b0, E_MC, "rst_mc_start");
        mc_body(1, 4, "rst_mc_hold");
        stallreq_id = 1'b1;
        ex_mc_start = 1'b1;
        exp_q.push_back('{v: E_IDLE, nm: "reset_mid_mc_cycle"});
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async_immediate", {22'd0, act}, 32'd0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "reset_mid_mc_hold");
        for (int k = 0; k < 35; k++) step(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "no_stray_done");
`ifdef STALL_PERF_EN
        chk("perf_cleared", perf, 32'd0);
        force dut.perf_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_q;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, E_ID, "sat_load_use");
        chk("perf_saturate", perf, 32'hFFFF_FFFF);
`endif

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
